// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the PC sequencer
// Contents:
//   pc_state_t           sequencer FSM state (RUN / STALL / HALT)
//   STACK_DEPTH          return-address stack depth
//   DEFAULT_RESET_VECTOR default PC value loaded on reset
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } pc_state_t;

    localparam int          STACK_DEPTH          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_ret_stack.sv
// rtl/pc_ret_stack.sv - small LIFO of return addresses for call/ret
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the stack)
//   push, push_data write push_data on top; ignored when full
//   pop             drop the top entry; ignored when empty
//   top             current top entry (0 when empty)
//   full, empty     occupancy flags
module pc_ret_stack
    import pc_seq_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] count;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign top   = empty ? '0 : mem[PW'(count - CW'(1))];

    // Entries are not cleared on reset; count alone defines validity.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (push && !full) begin
            mem[PW'(count)] <= push_data;
            count           <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with fetch handshake, jump, stall and halt
// Optional feature macro: PC_SEQ_CALL_STACK_EN (4-entry return-address stack for call/ret)
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   pc               current fetch address (registered)
//   fetch_req        fetch request to imem, high only in RUN
//   fetch_ack        imem acknowledge; advances pc by one in RUN
//   jump/jump_target redirect request and address
//   stall            hold pc and drop fetch_req
//   halt, resume     stop / restart requests
//   halted           high while in HALT
//   pc_wrap          one-cycle pulse when an increment wraps all-ones to 0
//   call, ret        subroutine call / return
//   stack_err        sticky overflow/underflow/conflict flag (0 without the stack)
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int           N            = 32,
    parameter logic [N-1:0] RESET_VECTOR = N'(DEFAULT_RESET_VECTOR)
) (
    input  logic         clk,
    input  logic         rst,
    output logic [N-1:0] pc,
    output logic         fetch_req,
    input  logic         fetch_ack,
    input  logic         jump,
    input  logic [N-1:0] jump_target,
    input  logic         stall,
    input  logic         halt,
    input  logic         resume,
    output logic         halted,
    output logic         pc_wrap,
    input  logic         call,
    input  logic         ret,
    output logic         stack_err
);

    pc_state_t    state, state_nxt;
    logic [N-1:0] pc_inc;
    logic [N-1:0] pc_nxt;
    logic         inc_sel;
    logic         err_set;
    logic         ret_eff;
    logic         active;
    logic         redir_evt;
    logic         ack_evt;
    logic         stk_push;
    logic         stk_pop;
    logic         stk_full;
    logic         stk_empty;
    logic [N-1:0] stk_top;

    assign pc_inc = pc + N'(1);

`ifdef PC_SEQ_CALL_STACK_EN
    assign ret_eff = ret;

    pc_ret_stack #(
        .W     (N),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );
`else
    logic unused_ret;
    assign unused_ret = ret;
    assign ret_eff    = 1'b0;
    assign stk_top    = '0;
    assign stk_full   = 1'b0;
    assign stk_empty  = 1'b1;
`endif

    // Event decode: halt > (jump | call | ret) > stall > fetch_ack.
    // Nothing but resume has any effect while halted.
    assign active    = (state != ST_HALT);
    assign redir_evt = active && !halt && (jump || call || ret_eff);
    assign ack_evt   = (state == ST_RUN) && !halt && !redir_evt && !stall && fetch_ack;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN, ST_STALL: begin
                if (halt) begin
                    state_nxt = ST_HALT;
                end else if (redir_evt) begin
                    state_nxt = ST_RUN;
                end else if (stall) begin
                    state_nxt = ST_STALL;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume && !halt) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        fetch_req = (state == ST_RUN);
        halted    = (state == ST_HALT);
    end

    // Next-pc selection and stack control.
    // A call always redirects to jump_target even when the push is dropped;
    // a ret on an empty stack falls through to sequential execution.
    always_comb begin
        pc_nxt   = pc;
        inc_sel  = 1'b0;
        err_set  = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (redir_evt) begin
            if (call) begin
                pc_nxt = jump_target;
`ifdef PC_SEQ_CALL_STACK_EN
                if (stk_full) begin
                    err_set = 1'b1;
                end else begin
                    stk_push = 1'b1;
                end
                if (ret_eff) begin
                    err_set = 1'b1;
                end
`endif
            end else if (ret_eff) begin
                if (stk_empty) begin
                    err_set = 1'b1;
                    pc_nxt  = pc_inc;
                    inc_sel = 1'b1;
                end else begin
                    stk_pop = 1'b1;
                    pc_nxt  = stk_top;
                end
            end else begin
                pc_nxt = jump_target;
            end
        end else if (ack_evt) begin
            pc_nxt  = pc_inc;
            inc_sel = 1'b1;
        end
    end

    // pc_wrap is registered alongside pc so it is high in the same cycle pc reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_VECTOR;
            pc_wrap <= 1'b0;
        end else begin
            pc      <= pc_nxt;
            pc_wrap <= inc_sel && (&pc);
        end
    end

`ifdef PC_SEQ_CALL_STACK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign stack_err = err_q;
`else
    logic unused_stack;
    assign unused_stack = err_set | stk_push | stk_pop | stk_full | stk_empty | (|stk_top);
    assign stack_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed table-driven bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        rst, fetch_ack, jump, stall, halt, resume, call, ret;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic        fetch_req, halted, pc_wrap, stack_err;

    // 8-bit instance for wrap checks
    logic        rst8, ack8, jump8;
    logic [7:0]  tgt8;
    logic [7:0]  pc8;
    logic        req8, halted8, wrap8, err8;

    pc_sequencer #(.N(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .fetch_req   (fetch_req),
        .fetch_ack   (fetch_ack),
        .jump        (jump),
        .jump_target (jump_target),
        .stall       (stall),
        .halt        (halt),
        .resume      (resume),
        .halted      (halted),
        .pc_wrap     (pc_wrap),
        .call        (call),
        .ret         (ret),
        .stack_err   (stack_err)
    );

    pc_sequencer #(.N(8), .RESET_VECTOR(8'h00)) dut8 (
        .clk         (clk),
        .rst         (rst8),
        .pc          (pc8),
        .fetch_req   (req8),
        .fetch_ack   (ack8),
        .jump        (jump8),
        .jump_target (tgt8),
        .stall       (1'b0),
        .halt        (1'b0),
        .resume      (1'b0),
        .halted      (halted8),
        .pc_wrap     (wrap8),
        .call        (1'b0),
        .ret         (1'b0),
        .stack_err   (err8)
    );

    typedef struct {
        string       name;
        logic        rst, halt, resume, jump, stall, ack, call, ret;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic        e_req, e_halted, e_wrap, e_err;
    } vec_t;

    vec_t tv[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; halt = 0; resume = 0; jump = 0; stall = 0;
        fetch_ack = 0; call = 0; ret = 0; jump_target = '0;
    endtask

    //                  name        rst hlt res jmp stl ack cal ret tgt      pc       req hlt wrp err
    task automatic add(input string n, input logic r, input logic h, input logic rs, input logic j,
                       input logic s, input logic a, input logic c, input logic rt, input logic [31:0] t,
                       input logic [31:0] p, input logic q, input logic hd, input logic w, input logic e);
        tv.push_back('{n, r, h, rs, j, s, a, c, rt, t, p, q, hd, w, e});
    endtask

    logic [31:0] exp_ret_pc, exp_ret_empty_pc;
    logic        exp_ret_empty_err;

    initial begin
        idle();
        rst8 = 1; ack8 = 0; jump8 = 0; tgt8 = '0;

`ifdef PC_SEQ_CALL_STACK_EN
        exp_ret_pc        = 32'h0000_000B;
        exp_ret_empty_pc  = 32'h0000_000C;
        exp_ret_empty_err = 1'b1;
`else
        exp_ret_pc        = 32'h0000_0041;
        exp_ret_empty_pc  = 32'h0000_0041;
        exp_ret_empty_err = 1'b0;
`endif

        add("reset",        1,0,0,0,0,0,0,0, 32'h0,   32'h0,   1,0,0,0);
        add("reset_ovr",    1,1,0,1,1,1,1,0, 32'h55,  32'h0,   1,0,0,0);
        add("first_req",    0,0,0,0,0,0,0,0, 32'h0,   32'h0,   1,0,0,0);
        add("ack1",         0,0,0,0,0,1,0,0, 32'h0,   32'h1,   1,0,0,0);
        add("ack2",         0,0,0,0,0,1,0,0, 32'h0,   32'h2,   1,0,0,0);
        add("ack3",         0,0,0,0,0,1,0,0, 32'h0,   32'h3,   1,0,0,0);
        add("wait_state",   0,0,0,0,0,0,0,0, 32'h0,   32'h3,   1,0,0,0);
        add("jump5",        0,0,0,1,0,0,0,0, 32'h5,   32'h5,   1,0,0,0);
        add("jump_ack",     0,0,0,1,0,1,0,0, 32'h100, 32'h100, 1,0,0,0);
        add("jump7",        0,0,0,1,0,0,0,0, 32'h7,   32'h7,   1,0,0,0);
        add("stall1",       0,0,0,0,1,1,0,0, 32'h0,   32'h7,   0,0,0,0);
        add("stall2",       0,0,0,0,1,1,0,0, 32'h0,   32'h7,   0,0,0,0);
        add("stall3",       0,0,0,0,1,1,0,0, 32'h0,   32'h7,   0,0,0,0);
        add("unstall",      0,0,0,0,0,1,0,0, 32'h0,   32'h7,   1,0,0,0);
        add("ack8",         0,0,0,0,0,1,0,0, 32'h0,   32'h8,   1,0,0,0);
        add("ack9",         0,0,0,0,0,1,0,0, 32'h0,   32'h9,   1,0,0,0);
        add("halt",         0,1,0,1,1,1,0,0, 32'h33,  32'h9,   0,1,0,0);
        add("halt_jmp1",    0,0,0,1,0,1,0,0, 32'h33,  32'h9,   0,1,0,0);
        add("halt_jmp2",    0,0,0,1,0,1,0,0, 32'h33,  32'h9,   0,1,0,0);
        add("halt_jmp3",    0,0,0,1,0,1,0,0, 32'h33,  32'h9,   0,1,0,0);
        add("halt_call",    0,0,0,0,0,1,1,0, 32'h33,  32'h9,   0,1,0,0);
        add("halt_res_blk", 0,1,1,0,0,0,0,0, 32'h0,   32'h9,   0,1,0,0);
        add("resume",       0,0,1,0,0,0,0,0, 32'h0,   32'h9,   1,0,0,0);
        add("ack_a",        0,0,0,0,0,1,0,0, 32'h0,   32'hA,   1,0,0,0);
        add("call40",       0,0,0,0,0,0,1,0, 32'h40,  32'h40,  1,0,0,0);
        add("ret_ack",      0,0,0,0,0,1,0,1, 32'h0,   exp_ret_pc, 1,0,0,0);
        add("ret_empty",    0,0,0,0,0,0,0,1, 32'h0,   exp_ret_empty_pc, 1,0,0,exp_ret_empty_err);
        add("jump_vs_stl",  0,0,0,1,1,0,0,0, 32'h200, 32'h200, 1,0,0,exp_ret_empty_err);
        add("stall_run",    0,0,0,0,1,0,0,0, 32'h0,   32'h200, 0,0,0,exp_ret_empty_err);
        add("jump_in_stl",  0,0,0,1,1,1,0,0, 32'h300, 32'h300, 1,0,0,exp_ret_empty_err);
        add("halt_in_stl0", 0,0,0,0,1,0,0,0, 32'h0,   32'h300, 0,0,0,exp_ret_empty_err);
        add("halt_in_stl1", 0,1,0,0,1,0,0,0, 32'h0,   32'h300, 0,1,0,exp_ret_empty_err);
        add("reset2",       1,0,0,0,0,0,0,0, 32'h0,   32'h0,   1,0,0,0);

        #1;
        foreach (tv[i]) begin
            rst = tv[i].rst; halt = tv[i].halt; resume = tv[i].resume;
            jump = tv[i].jump; stall = tv[i].stall; fetch_ack = tv[i].ack;
            call = tv[i].call; ret = tv[i].ret; jump_target = tv[i].tgt;
            cyc();
            chk({tv[i].name, ".pc"},        pc,                tv[i].e_pc);
            chk({tv[i].name, ".fetch_req"}, {31'b0, fetch_req}, {31'b0, tv[i].e_req});
            chk({tv[i].name, ".halted"},    {31'b0, halted},    {31'b0, tv[i].e_halted});
            chk({tv[i].name, ".pc_wrap"},   {31'b0, pc_wrap},   {31'b0, tv[i].e_wrap});
            chk({tv[i].name, ".stack_err"}, {31'b0, stack_err}, {31'b0, tv[i].e_err});
        end
        idle();

        // 8-bit wrap: increment wraps with a pulse, jump to 0 does not
        rst8 = 1; cyc();
        rst8 = 0; jump8 = 1; tgt8 = 8'hFE; cyc();
        chk("w8.jump_fe", {24'b0, pc8}, 32'hFE);
        jump8 = 0; ack8 = 1; cyc();
        chk("w8.pc_ff",   {24'b0, pc8}, 32'hFF);
        chk("w8.nowrap",  {31'b0, wrap8}, 32'h0);
        cyc();
        chk("w8.pc_00",   {24'b0, pc8}, 32'h00);
        chk("w8.wrap",    {31'b0, wrap8}, 32'h1);
        ack8 = 0; cyc();
        chk("w8.wrap_1cy", {31'b0, wrap8}, 32'h0);
        chk("w8.hold0",   {24'b0, pc8}, 32'h00);
        jump8 = 1; tgt8 = 8'hFF; cyc();
        tgt8 = 8'h00; cyc();
        chk("w8.jump_00", {24'b0, pc8}, 32'h00);
        chk("w8.jmp_nowrap", {31'b0, wrap8}, 32'h0);
        chk("w8.req",     {31'b0, req8}, 32'h1);
        chk("w8.halted",  {31'b0, halted8}, 32'h0);
        chk("w8.err",     {31'b0, err8}, 32'h0);
        jump8 = 0; rst8 = 1; cyc();

`ifdef PC_SEQ_CALL_STACK_EN
        // Five nested calls from pc=0, then five rets
        rst = 1; cyc();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            call = 1; jump_target = 32'(16 * (i + 1)); cyc();
            chk($sformatf("call%0d.pc", i), pc, 32'(16 * (i + 1)));
            chk($sformatf("call%0d.err", i), {31'b0, stack_err}, {31'b0, (i == 4)});
        end
        call = 0;
        begin
            logic [31:0] rets [5];
            rets[0] = 32'h31; rets[1] = 32'h21; rets[2] = 32'h11; rets[3] = 32'h01; rets[4] = 32'h02;
            for (int i = 0; i < 5; i++) begin
                ret = 1; cyc();
                chk($sformatf("ret%0d.pc", i), pc, rets[i]);
                chk($sformatf("ret%0d.err", i), {31'b0, stack_err}, 32'h1);
            end
        end
        ret = 0;
        // call and ret together: acts as call, flags error
        rst = 1; cyc();
        rst = 0; call = 1; ret = 1; jump_target = 32'h80; cyc();
        chk("callret.pc",  pc, 32'h80);
        chk("callret.err", {31'b0, stack_err}, 32'h1);
        call = 0; cyc();
        chk("callret.pop", pc, 32'h01);
        idle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter N, default 32: PC and target width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 0: PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  as its single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  as a synchronous, active-high reset.
REQ-005 SHALL have port pc  output  N  as the current fetch address, registered.
REQ-006 SHALL have port fetch_req  output  1  as the instruction-fetch request to imem.
REQ-007 SHALL have port fetch_ack  input  1  as the imem acknowledge; ignored unless fetch_req=1.
REQ-008 SHALL have port jump  input  1  as the redirect request.
REQ-009 SHALL have port jump_target  input  N  as the redirect address.
REQ-010 SHALL have port stall  input  1  as the hold-PC request.
REQ-011 SHALL have ports halt and resume  input  1 each  as stop/restart requests.
REQ-012 SHALL have port halted  output  1  that is high in HALT.
REQ-013 SHALL have port pc_wrap  output  1  as a one-cycle pulse when increment wraps all-ones to 0.
REQ-014 SHALL have ports call, ret  input  1 each, and stack_err  output  1  (sticky).

Function
REQ-015 SHALL implement an FSM with states RUN, STALL, HALT; fetch_req=1 only in RUN.
REQ-016 SHALL resolve per-cycle priority as halt > jump > stall > fetch_ack.
REQ-017 SHALL, in any state except HALT, move to HALT when halt=1, holding pc.
REQ-018 SHALL leave HALT only on resume=1 with halt=0, entering RUN with pc unchanged; jump in HALT is ignored.
REQ-019 SHALL, in RUN or STALL with jump=1, load pc<=jump_target next cycle, enter RUN, and discard any same-cycle fetch_ack.
REQ-020 SHALL, in RUN with stall=1 (no jump), enter STALL, hold pc, and ignore same-cycle fetch_ack.
REQ-021 SHALL, in STALL with stall=0, return to RUN the next cycle with pc unchanged.
REQ-022 SHALL, in RUN with fetch_ack=1 and no higher-priority event, load pc<=pc+1 (modulo 2^N) next cycle.
REQ-023 SHALL hold pc while fetch_req=1 and fetch_ack=0 (wait states are unbounded).
REQ-024 SHALL pulse pc_wrap in the cycle pc changes from all-ones to 0 by increment only, never by jump.

Reset
REQ-025 SHALL, with rst=1, set pc=RESET_VECTOR, state=RUN, halted=0, pc_wrap=0, stack_err=0, stack empty; rst overrides all other inputs.
REQ-026 SHALL assert fetch_req in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL compile a 4-entry return-address stack only when macro PC_SEQ_CALL_STACK_EN is defined.
REQ-028 SHALL, with the macro, treat call (same priority as jump) as push pc+1 and pc<=jump_target; push when full is dropped, sets stack_err, and still jumps.
REQ-029 SHALL, with the macro, treat ret (same priority as jump) as pop into pc; pop when empty sets stack_err and does pc<=pc+1; call and ret together set stack_err and act as call.
REQ-030 SHALL, without the macro, treat call as jump, ignore ret, and tie stack_err to 0.

Structure
REQ-031 SHALL place the state enum, stack depth constant (4), and default reset vector in shared package pc_seq_pkg.
REQ-032 SHALL implement the return-address stack as sub-module pc_ret_stack (push, pop, full, empty, top).

Verification
REQ-033 SHALL cover reset then three acks: pc sequence 0 -> 1 -> 2 -> 3, fetch_req=1 throughout.
REQ-034 SHALL cover jump=1, target=0x100, with fetch_ack=1 at pc=5: next pc=0x100, not 6.
REQ-035 SHALL cover stall for 3 cycles at pc=7 with ack high: fetch_req=0, pc=7 held, then RUN; next ack gives pc=8.
REQ-036 SHALL cover halt at pc=9, then resume after 5 cycles: halted=1 for the duration, pc=9 on exit.
REQ-037 SHALL cover N=8 at pc=0xFF with ack: pc=0x00 and pc_wrap pulses for one cycle.
REQ-038 SHALL cover, with the macro, 5 nested calls then 5 rets: stack_err=1 after the fifth call, and the first four rets restore correct addresses.
